// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Optional build macro used by the top level: HAZ_PERF_CNT_EN.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $zero is hardwired, so a match against it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != REG_ZERO) && (a == b);
  endfunction

  function automatic fwd_sel_e fwd_select(input logic [4:0] src,
                                          input logic       regwritem,
                                          input logic [4:0] writeregm,
                                          input logic       regwritew,
                                          input logic [4:0] writeregw);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (regwritem && reg_match(src, writeregm)) begin
      sel = FWD_MEM;
    end else if (regwritew && reg_match(src, writeregw)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline (controller taps and datapath specifiers)
// and the hazard controller.
interface pipe_hazard_ctrl_if;

  logic [4:0]  rsd, rtd, rse, rte;
  logic [4:0]  writerege, writeregm, writeregw;
  logic        branchd;
  logic        regwritee, memtorege;
  logic        regwritem, memtoregm, memwritem;
  logic        regwritew;
  logic        dmem_ack;

  logic        forwardad, forwardbd;
  logic [1:0]  forwardae, forwardbe;
  logic        stallf, stalld, stalle, stallm;
  logic        flushe, flushw;
  logic        dmem_req;
  logic        mem_err;
  logic [31:0] lwstall_cnt, brstall_cnt, memstall_cnt;

  modport master (
    output rsd, rtd, rse, rte, writerege, writeregm, writeregw,
           branchd, regwritee, memtorege, regwritem, memtoregm, memwritem,
           regwritew, dmem_ack,
    input  forwardad, forwardbd, forwardae, forwardbe,
           stallf, stalld, stalle, stallm, flushe, flushw,
           dmem_req, mem_err, lwstall_cnt, brstall_cnt, memstall_cnt
  );

  modport slave (
    input  rsd, rtd, rse, rte, writerege, writeregm, writeregw,
           branchd, regwritee, memtorege, regwritem, memtoregm, memwritem,
           regwritew, dmem_ack,
    output forwardad, forwardbd, forwardae, forwardbe,
           stallf, stalld, stalle, stallm, flushe, flushw,
           dmem_req, mem_err, lwstall_cnt, brstall_cnt, memstall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_mem_wait.sv
// Data-memory wait handshake: freezes the pipeline while an M-stage access is
// outstanding and latches a sticky error if the memory never answers.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic i_memaccm,
  input  logic i_dmem_ack,
  output logic o_dmem_req,
  output logic o_memstall,
  output logic o_mem_err
);

  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT_CYC);

  mem_state_e       r_state;
  mem_state_e       w_next_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_cnt_next;
  logic             r_mem_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_next_state == ERR) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // The counter holds the number of WAIT cycles entered; a miss while it
  // already equals TIMEOUT_CYC gives up and parks in ERR.
  always_comb begin
    w_next_state    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    o_dmem_req      = 1'b0;
    o_memstall      = 1'b0;
    case (r_state)
      IDLE: begin
        o_dmem_req = i_memaccm;
        if (i_memaccm && !i_dmem_ack) begin
          o_memstall      = 1'b1;
          w_next_state    = WAIT;
          w_wait_cnt_next = CNT_W'(1);
        end
      end
      WAIT: begin
        o_dmem_req = 1'b1;
        if (i_dmem_ack) begin
          w_next_state    = IDLE;
          w_wait_cnt_next = '0;
        end else begin
          o_memstall = 1'b1;
          if (r_wait_cnt >= LP_TIMEOUT) begin
            w_next_state = ERR;
          end else begin
            w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
          end
        end
      end
      ERR: begin
        o_memstall = 1'b1;
      end
      default: begin
        w_next_state    = IDLE;
        w_wait_cnt_next = '0;
      end
    endcase
    // Reset drops the request and the freeze at once, not at the next edge.
    if (reset) begin
      o_dmem_req = 1'b0;
      o_memstall = 1'b0;
    end
  end

  assign o_mem_err = r_mem_err;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage MIPS pipeline: forwarding selects,
// load-use/branch stalls and the data-memory freeze. Macro: HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);

  logic w_lwstall;
  logic w_brstall;
  logic w_memaccm;
  logic w_memstall;
  logic w_dmem_req;
  logic w_mem_err;

  assign w_lwstall = hz.memtorege &
                     (reg_match(hz.rte, hz.rsd) | reg_match(hz.rte, hz.rtd));

  assign w_brstall = hz.branchd &
                     ((hz.regwritee &
                       (reg_match(hz.writerege, hz.rsd) | reg_match(hz.writerege, hz.rtd))) |
                      (hz.memtoregm &
                       (reg_match(hz.writeregm, hz.rsd) | reg_match(hz.writeregm, hz.rtd))));

  assign w_memaccm = hz.memtoregm | hz.memwritem;

  assign hz.forwardae = fwd_select(hz.rse, hz.regwritem, hz.writeregm,
                                   hz.regwritew, hz.writeregw);
  assign hz.forwardbe = fwd_select(hz.rte, hz.regwritem, hz.writeregm,
                                   hz.regwritew, hz.writeregw);
  assign hz.forwardad = hz.regwritem & reg_match(hz.rsd, hz.writeregm);
  assign hz.forwardbd = hz.regwritem & reg_match(hz.rtd, hz.writeregm);

  mem_wait_fsm #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_mem_wait (
    .clk        (clk),
    .reset      (reset),
    .i_memaccm  (w_memaccm),
    .i_dmem_ack (i_ack_unused_guard(hz.dmem_ack)),
    .o_dmem_req (w_dmem_req),
    .o_memstall (w_memstall),
    .o_mem_err  (w_mem_err)
  );

  assign hz.dmem_req = w_dmem_req;
  assign hz.mem_err  = w_mem_err;

  function automatic logic i_ack_unused_guard(input logic a);
    return a;
  endfunction

  // A memory freeze holds every stage and overrides the D-stage hazards,
  // which get re-evaluated once the access releases.
  always_comb begin
    hz.stallf = 1'b0;
    hz.stalld = 1'b0;
    hz.stalle = 1'b0;
    hz.stallm = 1'b0;
    hz.flushe = 1'b0;
    hz.flushw = 1'b0;
    if (w_memstall) begin
      hz.stallf = 1'b1;
      hz.stalld = 1'b1;
      hz.stalle = 1'b1;
      hz.stallm = 1'b1;
      hz.flushw = 1'b1;
    end else begin
      hz.stallf = w_lwstall | w_brstall;
      hz.stalld = w_lwstall | w_brstall;
      hz.flushe = w_lwstall | w_brstall;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_lwstall_cnt;
  logic [31:0] r_brstall_cnt;
  logic [31:0] r_memstall_cnt;

  // Each stall cycle is attributed to exactly one cause; ERR cycles are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lwstall_cnt  <= 32'd0;
      r_brstall_cnt  <= 32'd0;
      r_memstall_cnt <= 32'd0;
    end else begin
      if (w_lwstall && !w_memstall) begin
        r_lwstall_cnt <= r_lwstall_cnt + 32'd1;
      end
      if (w_brstall && !w_lwstall && !w_memstall) begin
        r_brstall_cnt <= r_brstall_cnt + 32'd1;
      end
      if (w_memstall && !w_mem_err) begin
        r_memstall_cnt <= r_memstall_cnt + 32'd1;
      end
    end
  end

  assign hz.lwstall_cnt  = r_lwstall_cnt;
  assign hz.brstall_cnt  = r_brstall_cnt;
  assign hz.memstall_cnt = r_memstall_cnt;
`else
  assign hz.lwstall_cnt  = 32'd0;
  assign hz.brstall_cnt  = 32'd0;
  assign hz.memstall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, hand-written
// memory-wait/timeout/async-reset sequences, then randomized cycles vs a model.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_ERR   = 2;

  typedef struct packed {
    logic [4:0] rsd, rtd, rse, rte, writerege, writeregm, writeregw;
    logic       branchd, regwritee, memtorege, regwritem, memtoregm, memwritem;
    logic       regwritew, dmem_ack;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [12:0] expOut;
    string       name;
  } vec_t;

  logic clk;
  logic reset;
  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(.TIMEOUT_CYC(TIMEOUT), .CNT_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  stim_t       cur;
  vec_t        vecs[$];
  int          mState;
  int          mCnt;
  logic [31:0] mLw, mBr, mMem;

  // Output bundle order: forwardae, forwardbe, forwardad, forwardbd,
  // stallf, stalld, stalle, stallm, flushe, flushw, dmem_req.
  function automatic logic [12:0] dutOut();
    return {hz.forwardae, hz.forwardbe, hz.forwardad, hz.forwardbd,
            hz.stallf, hz.stalld, hz.stalle, hz.stallm,
            hz.flushe, hz.flushw, hz.dmem_req};
  endfunction

  function automatic bit rm(logic [4:0] a, logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwdE(logic [4:0] src, stim_t s);
    if (s.regwritem && rm(src, s.writeregm)) return 2'b10;
    if (s.regwritew && rm(src, s.writeregw)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit modelLw(stim_t s);
    return s.memtorege && (rm(s.rte, s.rsd) || rm(s.rte, s.rtd));
  endfunction

  function automatic bit modelBr(stim_t s);
    bit eHit, mHit;
    eHit = s.regwritee && (rm(s.writerege, s.rsd) || rm(s.writerege, s.rtd));
    mHit = s.memtoregm && (rm(s.writeregm, s.rsd) || rm(s.writeregm, s.rtd));
    return s.branchd && (eHit || mHit);
  endfunction

  function automatic bit modelMemStall(stim_t s);
    bit acc;
    acc = s.memtoregm || s.memwritem;
    if (reset) return 1'b0;
    if (mState == M_ERR) return 1'b1;
    if (mState == M_WAIT) return !s.dmem_ack;
    return acc && !s.dmem_ack;
  endfunction

  function automatic bit modelReq(stim_t s);
    if (reset) return 1'b0;
    if (mState == M_ERR) return 1'b0;
    if (mState == M_WAIT) return 1'b1;
    return s.memtoregm || s.memwritem;
  endfunction

  function automatic logic [12:0] modelOut(stim_t s);
    bit hzd, ms;
    logic [3:0] stl;
    logic [1:0] fl;
    hzd = modelLw(s) || modelBr(s);
    ms  = modelMemStall(s);
    stl = ms ? 4'b1111 : {hzd, hzd, 2'b00};
    fl  = ms ? 2'b01 : {hzd, 1'b0};
    return {fwdE(s.rse, s), fwdE(s.rte, s),
            s.regwritem && rm(s.rsd, s.writeregm),
            s.regwritem && rm(s.rtd, s.writeregm),
            stl, fl, modelReq(s)};
  endfunction

  function automatic logic [31:0] expCnt(logic [31:0] v);
`ifdef HAZ_PERF_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic checkOutput(input string name, input logic [12:0] expv);
    logic [12:0] act;
    act = dutOut();
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, expv);
    end
  endtask

  task automatic checkCounters(input string name);
    checkVal({name, "_lwcnt"},  hz.lwstall_cnt,  expCnt(mLw));
    checkVal({name, "_brcnt"},  hz.brstall_cnt,  expCnt(mBr));
    checkVal({name, "_memcnt"}, hz.memstall_cnt, expCnt(mMem));
  endtask

  task automatic applyStimulus(input stim_t s);
    cur          = s;
    hz.rsd       = s.rsd;       hz.rtd       = s.rtd;
    hz.rse       = s.rse;       hz.rte       = s.rte;
    hz.writerege = s.writerege; hz.writeregm = s.writeregm;
    hz.writeregw = s.writeregw; hz.branchd   = s.branchd;
    hz.regwritee = s.regwritee; hz.memtorege = s.memtorege;
    hz.regwritem = s.regwritem; hz.memtoregm = s.memtoregm;
    hz.memwritem = s.memwritem; hz.regwritew = s.regwritew;
    hz.dmem_ack  = s.dmem_ack;
    #1;
  endtask

  // Advance one clock, updating the reference model, and return at the negedge.
  task automatic stepClock();
    bit lw, br, ms;
    @(posedge clk);
    if (!reset) begin
      lw = modelLw(cur);
      br = modelBr(cur);
      ms = modelMemStall(cur);
      if (lw && !ms) mLw++;
      if (br && !lw && !ms) mBr++;
      if (ms && mState != M_ERR) mMem++;
      if (mState == M_IDLE) begin
        if ((cur.memtoregm || cur.memwritem) && !cur.dmem_ack) begin
          mState = M_WAIT;
          mCnt   = 1;
        end
      end else if (mState == M_WAIT) begin
        if (cur.dmem_ack) begin
          mState = M_IDLE;
          mCnt   = 0;
        end else if (mCnt >= TIMEOUT) begin
          mState = M_ERR;
        end else begin
          mCnt++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic modelReset();
    mState = M_IDLE;
    mCnt   = 0;
    mLw    = 0;
    mBr    = 0;
    mMem   = 0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    modelReset();
    applyStimulus('0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic addVec(input stim_t s, input logic [12:0] e, input string n);
    vec_t v;
    v.s      = s;
    v.expOut = e;
    v.name   = n;
    vecs.push_back(v);
  endtask

  initial begin
    stim_t s;
    stim_t stallAll;

    s = '0;
    s.memtorege = 1; s.rte = 5'd8; s.rsd = 5'd8;
    addVec(s, 13'b00_00_00_1100_10_0, "load_use");
    s = '0;
    s.regwritem = 1; s.writeregm = 5'd9; s.regwritew = 1; s.writeregw = 5'd9; s.rse = 5'd9;
    addVec(s, 13'b10_00_00_0000_00_0, "fwd_prio_mem");
    s.writeregm = 5'd3;
    addVec(s, 13'b01_00_00_0000_00_0, "fwd_prio_wb");
    s.rse = 5'd0;
    addVec(s, 13'b00_00_00_0000_00_0, "fwd_zero_reg");
    s = '0;
    s.branchd = 1; s.regwritee = 1; s.writerege = 5'd4; s.rtd = 5'd4;
    addVec(s, 13'b00_00_00_1100_10_0, "br_exec_dep");
    s = '0;
    s.branchd = 1; s.memtoregm = 1; s.writeregm = 5'd4; s.rtd = 5'd4; s.dmem_ack = 1;
    addVec(s, 13'b00_00_00_1100_10_1, "br_load_dep");
    s = '0;
    s.branchd = 1; s.regwritem = 1; s.writeregm = 5'd4; s.rtd = 5'd4;
    addVec(s, 13'b00_00_01_0000_00_0, "br_fwd_bd");
    s = '0;
    s.memtorege = 1; s.regwritem = 1; s.regwritew = 1; s.branchd = 1; s.regwritee = 1;
    addVec(s, 13'b00_00_00_0000_00_0, "all_zero_regs");
    s = '0;
    s.regwritem = 1; s.writeregm = 5'd5; s.rse = 5'd5; s.rsd = 5'd5;
    s.regwritew = 1; s.writeregw = 5'd6; s.rte = 5'd6; s.rtd = 5'd6;
    addVec(s, 13'b10_01_10_0000_00_0, "fwd_mixed");
    s = '0;
    s.writeregm = 5'd9; s.writeregw = 5'd9; s.rse = 5'd9;
    addVec(s, 13'b00_00_00_0000_00_0, "fwd_no_regwrite");
    s = '0;
    s.memtorege = 1; s.rte = 5'd12; s.rtd = 5'd12; s.rsd = 5'd3;
    s.regwritee = 1; s.writerege = 5'd12;
    addVec(s, 13'b00_00_00_1100_10_0, "load_use_rt");
    s = '0;
    s.memwritem = 1; s.dmem_ack = 1;
    addVec(s, 13'b00_00_00_0000_00_1, "mem_hit_no_stall");

    reset = 1'b1;
    modelReset();
    applyStimulus('0);
    @(negedge clk);
    checkOutput("reset_outputs", 13'b0);
    checkVal("reset_mem_err", {31'd0, hz.mem_err}, 32'd0);
    checkCounters("reset");
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s);
      checkOutput(vecs[i].name, vecs[i].expOut);
      stepClock();
    end
    checkCounters("table");

    // Memory wait: three misses then ack, with a load-use pending that must be ignored.
    doReset();
    s = '0;
    s.memwritem = 1; s.memtorege = 1; s.rte = 5'd8; s.rsd = 5'd8;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(s);
      checkOutput($sformatf("memwait_miss%0d", c), 13'b00_00_00_1111_01_1);
      stepClock();
    end
    s.dmem_ack = 1;
    applyStimulus(s);
    checkOutput("memwait_release", 13'b00_00_00_1100_10_1);
    stepClock();
    applyStimulus('0);
    checkOutput("memwait_after", 13'b0);
    stepClock();
    checkCounters("memwait");

    // Timeout: one IDLE miss, TIMEOUT wait cycles, then ERR holds forever.
    doReset();
    stallAll = '0;
    stallAll.memtoregm = 1;
    for (int c = 0; c <= TIMEOUT; c++) begin
      applyStimulus(stallAll);
      checkOutput($sformatf("timeout_wait%0d", c), 13'b00_00_00_1111_01_1);
      checkVal($sformatf("timeout_err_low%0d", c), {31'd0, hz.mem_err}, 32'd0);
      stepClock();
    end
    for (int c = 0; c < 2; c++) begin
      stallAll.dmem_ack = (c == 1);
      applyStimulus(stallAll);
      checkOutput($sformatf("timeout_err%0d", c), 13'b00_00_00_1111_01_0);
      checkVal($sformatf("timeout_err_flag%0d", c), {31'd0, hz.mem_err}, 32'd1);
      stepClock();
    end
    checkCounters("timeout");
    doReset();
    checkVal("err_cleared", {31'd0, hz.mem_err}, 32'd0);
    s = '0;
    s.memwritem = 1; s.dmem_ack = 1;
    applyStimulus(s);
    checkOutput("idle_after_err", 13'b00_00_00_0000_00_1);
    stepClock();

    // Asynchronous reset in the middle of a WAIT cycle.
    doReset();
    s = '0;
    s.memwritem = 1;
    applyStimulus(s);
    checkOutput("async_idle_miss", 13'b00_00_00_1111_01_1);
    stepClock();
    applyStimulus(s);
    checkOutput("async_in_wait", 13'b00_00_00_1111_01_1);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("async_rst_drop", 13'b0);
    checkVal("async_rst_err", {31'd0, hz.mem_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus('0);
    checkOutput("async_after", 13'b0);
    stepClock();

    // Randomized traffic against the reference model.
    doReset();
    for (int n = 0; n < 400; n++) begin
      s.rsd       = 5'($urandom_range(0, 7));
      s.rtd       = 5'($urandom_range(0, 7));
      s.rse       = 5'($urandom_range(0, 7));
      s.rte       = 5'($urandom_range(0, 7));
      s.writerege = 5'($urandom_range(0, 7));
      s.writeregm = 5'($urandom_range(0, 7));
      s.writeregw = 5'($urandom_range(0, 7));
      s.branchd   = 1'($urandom_range(0, 1));
      s.regwritee = 1'($urandom_range(0, 1));
      s.memtorege = 1'($urandom_range(0, 1));
      s.regwritem = 1'($urandom_range(0, 1));
      s.regwritew = 1'($urandom_range(0, 1));
      s.memtoregm = ($urandom_range(0, 3) == 0);
      s.memwritem = ($urandom_range(0, 3) == 0);
      s.dmem_ack  = 1'($urandom_range(0, 1));
      applyStimulus(s);
      checkOutput($sformatf("rand%0d", n), modelOut(s));
      checkVal($sformatf("rand_err%0d", n), {31'd0, hz.mem_err}, {31'd0, mState == M_ERR});
      stepClock();
      if (n % 50 == 49) checkCounters($sformatf("rand%0d", n));
      if (mState == M_ERR && $urandom_range(0, 2) == 0) doReset();
    end
    checkCounters("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
